// File: rtl/fifo_read_packer.sv
// Read-side packer for a CDC FIFO: gathers RATIO narrow words into one wide word,
// closing early on input_last or flush and flagging the filled lanes in output_keep.
module fifo_read_packer #(
    parameter int INPUT_WIDTH    = 8,
    parameter int RATIO          = 4,
    parameter int FIRST_LANE_LSB = 1
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         input_valid,
    output logic                         input_ready,
    input  logic [INPUT_WIDTH-1:0]       input_data,
    input  logic                         input_last,
    input  logic                         flush,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [INPUT_WIDTH*RATIO-1:0] output_data,
    output logic [RATIO-1:0]             output_keep,
    output logic                         output_last
);

    localparam int CW = $clog2(RATIO);
    localparam int OW = INPUT_WIDTH * RATIO;

    logic [CW-1:0]          lane_count;
    logic [INPUT_WIDTH-1:0] acc [RATIO];
    logic                   flush_pending;

    logic                   accept;
    logic                   flush_req;
    logic                   complete;
    logic                   partial_load;
    logic                   hold_flush;
    logic                   lane_used;
    logic [INPUT_WIDTH-1:0] lane_word;
    int unsigned            phys;
    logic [OW-1:0]          next_data;
    logic [RATIO-1:0]       next_keep;

    always_comb begin
        input_ready  = !output_valid || output_ready;
        accept       = input_valid && input_ready;
        // A pending flush is honoured by the next accepted word as well as by an idle load.
        flush_req    = flush || flush_pending;
        complete     = accept && ((lane_count == CW'(RATIO - 1)) || input_last || flush_req);
        partial_load = !accept && flush_req && (lane_count != '0) && input_ready;
        hold_flush   = !accept && flush_req && (lane_count != '0) && !input_ready;
    end

    always_comb begin
        next_data = '0;
        next_keep = '0;
        lane_used = 1'b0;
        lane_word = '0;
        phys      = 0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            lane_word = acc[i];
            if (accept && (CW'(i) == lane_count)) begin
                lane_word = input_data;
            end
            lane_used = complete ? (CW'(i) <= lane_count) : (CW'(i) < lane_count);
            phys      = (FIRST_LANE_LSB != 0) ? i : (RATIO - 1 - i);
            if (lane_used) begin
                next_data[phys*INPUT_WIDTH +: INPUT_WIDTH] = lane_word;
                next_keep[phys]                            = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            lane_count    <= '0;
            flush_pending <= 1'b0;
            for (int unsigned i = 0; i < RATIO; i++) begin
                acc[i] <= '0;
            end
        end else if (complete || partial_load) begin
            lane_count    <= '0;
            flush_pending <= 1'b0;
            for (int unsigned i = 0; i < RATIO; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (accept) begin
                acc[lane_count] <= input_data;
                lane_count      <= lane_count + CW'(1);
            end
            if (hold_flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            output_valid <= 1'b0;
            output_data  <= '0;
            output_keep  <= '0;
            output_last  <= 1'b0;
        end else if (complete || partial_load) begin
            output_valid <= 1'b1;
            output_data  <= next_data;
            output_keep  <= next_keep;
            output_last  <= complete && input_last;
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Randomised and directed bench for fifo_read_packer against a queue-based model;
// an MSB-first instance shares the stimulus and is checked through lane reversal.
module tb_fifo_read_packer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        input_valid = 1'b0;
    logic [7:0]  input_data = '0;
    logic        input_last = 1'b0;
    logic        flush = 1'b0;
    logic        output_ready = 1'b0;

    logic        input_ready, output_valid, output_last;
    logic [31:0] output_data;
    logic [3:0]  output_keep;
    logic        msb_input_ready, msb_output_valid, msb_output_last;
    logic [31:0] msb_output_data;
    logic [3:0]  msb_output_keep;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  mq[$];
    logic [31:0] out_log[$];
    bit          m_pend;
    logic        m_ov;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    int          n_acc;

    fifo_read_packer #(.INPUT_WIDTH(8), .RATIO(4), .FIRST_LANE_LSB(1)) dut (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(input_ready),
        .input_data(input_data), .input_last(input_last), .flush(flush),
        .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
        .output_keep(output_keep), .output_last(output_last));

    fifo_read_packer #(.INPUT_WIDTH(8), .RATIO(4), .FIRST_LANE_LSB(0)) dut_msb (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(msb_input_ready),
        .input_data(input_data), .input_last(input_last), .flush(flush),
        .output_valid(msb_output_valid), .output_ready(output_ready), .output_data(msb_output_data),
        .output_keep(msb_output_keep), .output_last(msb_output_last));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rev_data(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[(3-i)*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [3:0] rev_keep(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_ov = 0; m_data = '0; m_keep = '0; m_last = 0;
    endtask

    // Advance one clock; the model consumes the inputs seen on the falling edge.
    task automatic tick();
        bit rdy, acc, load;
        logic lst;
        @(negedge clock);
        if (!clear) begin
            model_reset();
        end else begin
            rdy = !m_ov || output_ready;
            acc = input_valid && rdy;
            load = 0; lst = 0;
            if (m_ov && output_ready) out_log.push_back(m_data);
            if (acc) begin
                n_acc++;
                mq.push_back(input_data);
                if (mq.size() == 4 || input_last || flush || m_pend) begin
                    load = 1; lst = input_last;
                end
            end else if ((flush || m_pend) && mq.size() > 0) begin
                if (rdy) load = 1;
                else m_pend = 1;
            end
            if (load) begin
                m_data = '0; m_keep = '0;
                foreach (mq[i]) begin
                    m_data[i*8 +: 8] = mq[i];
                    m_keep[i] = 1'b1;
                end
                m_ov = 1; m_last = lst; m_pend = 0;
                mq.delete();
            end else if (m_ov && output_ready) begin
                m_ov = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic f);
        input_valid = 1; input_data = d; input_last = l; flush = f;
        tick();
        input_valid = 0; input_last = 0; flush = 0;
    endtask

    task automatic test_reset();
        clear = 0; output_ready = 0;
        model_reset();
        tick(); tick();
        checks += 6;
        if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", output_valid); end
        if (output_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", output_data); end
        if (output_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %b want 0000", output_keep); end
        if (output_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", output_last); end
        if (msb_output_valid !== 1'b0) begin errors++; $display("FAIL reset_msb_valid: got %b want 0", msb_output_valid); end
        if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", input_ready); end
        clear = 1;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", output_valid); end
    endtask

    task automatic test_full_words();
        output_ready = 1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (input_ready !== 1'b1) begin errors++; $display("FAIL full_ready k=%0d: got %b want 1", k, input_ready); end
            send(8'((k + 1) * 8'h11), 0, 0);
            if (k == 3 || k == 7) begin
                checks += 5;
                if (output_valid !== 1'b1) begin errors++; $display("FAIL full_valid k=%0d: got %b want 1", k, output_valid); end
                if (output_data !== (k == 3 ? 32'h44332211 : 32'h88776655))
                    begin errors++; $display("FAIL full_data k=%0d: got %h", k, output_data); end
                if (output_keep !== 4'b1111) begin errors++; $display("FAIL full_keep k=%0d: got %b want 1111", k, output_keep); end
                if (output_last !== 1'b0) begin errors++; $display("FAIL full_last k=%0d: got %b want 0", k, output_last); end
                if (msb_output_data !== (k == 3 ? 32'h11223344 : 32'h55667788))
                    begin errors++; $display("FAIL full_msb_data k=%0d: got %h", k, msb_output_data); end
            end else begin
                checks++;
                if (output_valid !== 1'b0) begin errors++; $display("FAIL full_idle k=%0d: got %b want 0", k, output_valid); end
            end
        end
        tick();
    endtask

    task automatic test_last();
        output_ready = 1;
        send(8'hA1, 0, 0);
        send(8'hA2, 0, 0);
        checks++;
        if (output_valid !== 1'b0) begin errors++; $display("FAIL last_early: got %b want 0", output_valid); end
        send(8'hA3, 1, 0);
        checks += 6;
        if (output_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b want 1", output_valid); end
        if (output_data !== 32'h00A3A2A1) begin errors++; $display("FAIL last_data: got %h want 00a3a2a1", output_data); end
        if (output_keep !== 4'b0111) begin errors++; $display("FAIL last_keep: got %b want 0111", output_keep); end
        if (output_last !== 1'b1) begin errors++; $display("FAIL last_last: got %b want 1", output_last); end
        if (msb_output_data !== 32'hA1A2A300) begin errors++; $display("FAIL last_msb_data: got %h want a1a2a300", msb_output_data); end
        if (msb_output_keep !== 4'b1110) begin errors++; $display("FAIL last_msb_keep: got %b want 1110", msb_output_keep); end
        send(8'hB1, 1, 0);
        checks += 4;
        if (output_data !== 32'h000000B1) begin errors++; $display("FAIL first_last_data: got %h want 000000b1", output_data); end
        if (output_keep !== 4'b0001) begin errors++; $display("FAIL first_last_keep: got %b want 0001", output_keep); end
        if (output_last !== 1'b1) begin errors++; $display("FAIL first_last_last: got %b want 1", output_last); end
        if (msb_output_keep !== 4'b1000) begin errors++; $display("FAIL first_last_msb_keep: got %b want 1000", msb_output_keep); end
        tick();
    endtask

    task automatic test_flush();
        output_ready = 1;
        send(8'h55, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (output_valid !== 1'b0) begin errors++; $display("FAIL flush_idle k=%0d: got %b want 0", k, output_valid); end
        end
        flush = 1; tick(); flush = 0;
        checks += 4;
        if (output_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b want 1", output_valid); end
        if (output_data !== 32'h00000055) begin errors++; $display("FAIL flush_data: got %h want 00000055", output_data); end
        if (output_keep !== 4'b0001) begin errors++; $display("FAIL flush_keep: got %b want 0001", output_keep); end
        if (output_last !== 1'b0) begin errors++; $display("FAIL flush_last: got %b want 0", output_last); end
        flush = 1; tick(); flush = 0;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", output_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [8];
        int idx, acc0, log0, cyc;
        bit rdy;
        for (int i = 0; i < 8; i++) words[i] = 8'h31 + 8'(i);
        idx = 0; acc0 = n_acc; log0 = out_log.size();
        output_ready = 0;
        for (int k = 0; k < 6; k++) begin
            rdy = !m_ov || output_ready;
            input_valid = 1; input_data = words[idx];
            tick();
            if (rdy) idx++;
        end
        checks += 3;
        if (n_acc - acc0 != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", n_acc - acc0); end
        if (input_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", input_ready); end
        if (output_data !== 32'h34333231) begin errors++; $display("FAIL bp_data: got %h want 34333231", output_data); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 2;
            if (output_valid !== 1'b1 || output_data !== 32'h34333231)
                begin errors++; $display("FAIL bp_hold k=%0d: got %b/%h want 1/34333231", k, output_valid, output_data); end
            if (input_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready k=%0d: got %b want 0", k, input_ready); end
        end
        output_ready = 1;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            rdy = !m_ov || output_ready;
            input_valid = 1; input_data = words[idx];
            tick();
            if (rdy) idx++;
            cyc++;
        end
        input_valid = 0;
        tick(); tick();
        checks++;
        if (idx != 8) begin errors++; $display("FAIL bp_drain_bound: got %0d words sent want 8", idx); end
        checks += 3;
        if (out_log.size() - log0 != 2) begin errors++; $display("FAIL bp_count: got %0d words want 2", out_log.size() - log0); end
        else begin
            if (out_log[log0] !== 32'h34333231) begin errors++; $display("FAIL bp_order0: got %h want 34333231", out_log[log0]); end
            if (out_log[log0+1] !== 32'h38373635) begin errors++; $display("FAIL bp_order1: got %h want 38373635", out_log[log0+1]); end
        end
    endtask

    task automatic test_async_clear();
        output_ready = 1;
        for (int k = 0; k < 4; k++) send(8'h41 + 8'(k), 0, 0);
        output_ready = 0;
        #2 clear = 0;
        #1;
        checks += 5;
        if (output_valid !== 1'b0) begin errors++; $display("FAIL aclr_valid: got %b want 0", output_valid); end
        if (output_data !== 32'h0) begin errors++; $display("FAIL aclr_data: got %h want 0", output_data); end
        if (output_keep !== 4'h0) begin errors++; $display("FAIL aclr_keep: got %b want 0", output_keep); end
        if (output_last !== 1'b0) begin errors++; $display("FAIL aclr_last: got %b want 0", output_last); end
        if (msb_output_valid !== 1'b0) begin errors++; $display("FAIL aclr_msb_valid: got %b want 0", msb_output_valid); end
        model_reset();
        @(posedge clock); #1;
        clear = 1;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin errors++; $display("FAIL aclr_after: got %b want 0", output_valid); end
        output_ready = 1;
        send(8'h51, 0, 0);
        send(8'h52, 0, 0);
        #2 clear = 0;
        #1;
        model_reset();
        @(posedge clock); #1;
        clear = 1;
        for (int k = 0; k < 4; k++) send(8'h61 + 8'(k), 0, 0);
        checks += 2;
        if (output_data !== 32'h64636261) begin errors++; $display("FAIL aclr_new_data: got %h want 64636261", output_data); end
        if (output_keep !== 4'b1111) begin errors++; $display("FAIL aclr_new_keep: got %b want 1111", output_keep); end
        tick();
    endtask

    task automatic test_msb_first();
        output_ready = 1;
        for (int k = 0; k < 4; k++) send(8'h01 + 8'(k), 0, 0);
        checks += 4;
        if (msb_output_valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b want 1", msb_output_valid); end
        if (msb_output_data !== 32'h01020304) begin errors++; $display("FAIL msb_data: got %h want 01020304", msb_output_data); end
        if (msb_output_keep !== 4'b1111) begin errors++; $display("FAIL msb_keep: got %b want 1111", msb_output_keep); end
        if (output_data !== 32'h04030201) begin errors++; $display("FAIL msb_lsb_data: got %h want 04030201", output_data); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            input_valid  = ($urandom_range(0, 3) != 0);
            input_data   = 8'($urandom);
            input_last   = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            output_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks += 2;
            if (input_ready !== (!m_ov || output_ready))
                begin errors++; $display("FAIL rnd_ready k=%0d: got %b want %b", k, input_ready, !m_ov || output_ready); end
            if (msb_input_ready !== input_ready)
                begin errors++; $display("FAIL rnd_msb_ready k=%0d: got %b want %b", k, msb_input_ready, input_ready); end
            tick();
            checks += 2;
            if (output_valid !== m_ov) begin errors++; $display("FAIL rnd_valid k=%0d: got %b want %b", k, output_valid, m_ov); end
            if (msb_output_valid !== m_ov) begin errors++; $display("FAIL rnd_msb_valid k=%0d: got %b want %b", k, msb_output_valid, m_ov); end
            if (m_ov) begin
                checks += 5;
                if (output_data !== m_data) begin errors++; $display("FAIL rnd_data k=%0d: got %h want %h", k, output_data, m_data); end
                if (output_keep !== m_keep) begin errors++; $display("FAIL rnd_keep k=%0d: got %b want %b", k, output_keep, m_keep); end
                if (output_last !== m_last) begin errors++; $display("FAIL rnd_last k=%0d: got %b want %b", k, output_last, m_last); end
                if (msb_output_data !== rev_data(m_data))
                    begin errors++; $display("FAIL rnd_msb_data k=%0d: got %h want %h", k, msb_output_data, rev_data(m_data)); end
                if (msb_output_keep !== rev_keep(m_keep))
                    begin errors++; $display("FAIL rnd_msb_keep k=%0d: got %b want %b", k, msb_output_keep, rev_keep(m_keep)); end
            end
        end
        input_valid = 0; input_last = 0; flush = 0; output_ready = 1;
        tick(); tick();
    endtask

    initial begin
        n_acc = 0;
        model_reset();
        test_reset();
        test_full_words();
        test_last();
        test_flush();
        test_back_to_back();
        test_async_clear();
        test_msb_first();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
